// File: rtl/switch_alloc.sv
// rtl/switch_alloc.sv - 5-port wormhole switch allocator with round-robin arbitration and crossbar
module switch_alloc #(
  parameter int NUM_PORTS = 5,
  parameter int FLIT_W    = 16,
  parameter int PORT_W    = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_PORTS-1:0]          req_valid_i,
  input  logic [NUM_PORTS*PORT_W-1:0]   req_port_i,
  input  logic [NUM_PORTS-1:0]          tail_i,
  input  logic [NUM_PORTS*FLIT_W-1:0]   flit_i,
  input  logic [NUM_PORTS-1:0]          out_ready_i,
  output logic [NUM_PORTS-1:0]          grant_o,
  output logic [NUM_PORTS-1:0]          out_valid_o,
  output logic [NUM_PORTS*FLIT_W-1:0]   out_flit_o,
  output logic [NUM_PORTS*PORT_W-1:0]   out_src_o,
  output logic [NUM_PORTS-1:0]          busy_o,
  output logic                          err_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state_q [NUM_PORTS];
  logic [PORT_W-1:0]   owner_q [NUM_PORTS];
  logic [PORT_W-1:0]   ptr_q   [NUM_PORTS];
  logic                err_q;

  logic [NUM_PORTS-1:0] found;
  logic [NUM_PORTS-1:0] xfer;
  logic [PORT_W-1:0]    win     [NUM_PORTS];
  logic [PORT_W:0]      sum;
  logic [PORT_W-1:0]    cand;
  logic                 bad_req;

  // Pick one input per output: the lock owner when locked, else first requester after ptr
  always_comb begin
    found = '0;
    xfer  = '0;
    sum   = '0;
    cand  = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      win[j] = '0;
      if (state_q[j] == LOCKED) begin
        if (req_valid_i[owner_q[j]] &&
            req_port_i[owner_q[j]*PORT_W +: PORT_W] == PORT_W'(j)) begin
          found[j] = 1'b1;
          win[j]   = owner_q[j];
        end
      end else begin
        for (int k = 1; k <= NUM_PORTS; k++) begin
          sum = {1'b0, ptr_q[j]} + (PORT_W+1)'(k);
          if (sum >= (PORT_W+1)'(NUM_PORTS)) begin
            sum = sum - (PORT_W+1)'(NUM_PORTS);
          end
          cand = sum[PORT_W-1:0];
          if (!found[j] && req_valid_i[cand] &&
              req_port_i[cand*PORT_W +: PORT_W] == PORT_W'(j)) begin
            found[j] = 1'b1;
            win[j]   = cand;
          end
        end
      end
      xfer[j] = found[j] && out_ready_i[j] && !rst_i;
    end
  end

  // Crossbar steering and queue pops for every output that transfers this cycle
  always_comb begin
    grant_o     = '0;
    out_valid_o = xfer;
    out_flit_o  = '0;
    out_src_o   = '0;
    busy_o      = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      busy_o[j] = (state_q[j] == LOCKED) && !rst_i;
      if (xfer[j]) begin
        grant_o[win[j]]                    = 1'b1;
        out_flit_o[j*FLIT_W +: FLIT_W]     = flit_i[win[j]*FLIT_W +: FLIT_W];
        out_src_o[j*PORT_W +: PORT_W]      = win[j];
      end
    end
  end

  // Any valid request naming a port beyond the last one is a protocol error
  always_comb begin
    bad_req = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_valid_i[i] && req_port_i[i*PORT_W +: PORT_W] > PORT_W'(NUM_PORTS-1)) begin
        bad_req = 1'b1;
      end
    end
  end

  assign err_o = err_q && !rst_i;

  // Per-output lock FSM, owner and round-robin pointer; sticky error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        state_q[j] <= IDLE;
        owner_q[j] <= '0;
        ptr_q[j]   <= PORT_W'(NUM_PORTS-1);
      end
      err_q <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (xfer[j]) begin
          if (tail_i[win[j]]) begin
            state_q[j] <= IDLE;
            ptr_q[j]   <= win[j];
          end else begin
            state_q[j] <= LOCKED;
            owner_q[j] <= win[j];
          end
        end
      end
      if (bad_req) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_alloc.sv
// tb/tb_switch_alloc.sv - self-checking bench for switch_alloc against a behavioural allocator model
module tb_switch_alloc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rv  = '0;
  logic [14:0] rp  = '0;
  logic [4:0]  tl  = '0;
  logic [79:0] fl  = '0;
  logic [4:0]  rdy = '1;
  logic [4:0]  grant, ovalid, busy;
  logic [79:0] oflit;
  logic [14:0] osrc;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  int          m_lock  [5];
  int          m_owner [5];
  int          m_ptr   [5];
  bit          m_err;
  int          e_win   [5];
  logic [4:0]  e_grant, e_valid, e_busy;
  logic [79:0] e_flit;
  logic [14:0] e_src;

  switch_alloc dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (rv),
    .req_port_i  (rp),
    .tail_i      (tl),
    .flit_i      (fl),
    .out_ready_i (rdy),
    .grant_o     (grant),
    .out_valid_o (ovalid),
    .out_flit_o  (oflit),
    .out_src_o   (osrc),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int port_of(int i);
    return int'((rp >> (3*i)) & 15'h7);
  endfunction

  function automatic bit valid_of(int i);
    return ((rv >> i) & 5'h1) != 5'h0;
  endfunction

  function automatic bit tail_of(int i);
    return ((tl >> i) & 5'h1) != 5'h0;
  endfunction

  function automatic bit ready_of(int j);
    return ((rdy >> j) & 5'h1) != 5'h0;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 5; j++) begin
      m_lock[j]  = 0;
      m_owner[j] = 0;
      m_ptr[j]   = 4;
    end
    m_err = 0;
  endtask

  // Expected outputs this cycle from the allocation rules
  task automatic model_eval();
    e_grant = '0; e_valid = '0; e_busy = '0; e_flit = '0; e_src = '0;
    for (int j = 0; j < 5; j++) begin
      e_win[j] = -1;
      if (m_lock[j] != 0) begin
        if (valid_of(m_owner[j]) && port_of(m_owner[j]) == j) e_win[j] = m_owner[j];
      end else begin
        for (int k = 1; k <= 5; k++) begin
          int i;
          i = (m_ptr[j] + k) % 5;
          if (e_win[j] < 0 && valid_of(i) && port_of(i) == j) e_win[j] = i;
        end
      end
      if (e_win[j] >= 0 && !ready_of(j)) e_win[j] = -1;
      if (e_win[j] >= 0) begin
        e_grant |= 5'(1) << e_win[j];
        e_valid |= 5'(1) << j;
        e_flit[j*16 +: 16] = fl[e_win[j]*16 +: 16];
        e_src[j*3 +: 3]    = 3'(e_win[j]);
      end
      if (m_lock[j] != 0) e_busy |= 5'(1) << j;
    end
  endtask

  task automatic model_commit();
    for (int j = 0; j < 5; j++) begin
      if (e_win[j] >= 0) begin
        if (tail_of(e_win[j])) begin
          m_lock[j] = 0;
          m_ptr[j]  = e_win[j];
        end else begin
          m_lock[j]  = 1;
          m_owner[j] = e_win[j];
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (valid_of(i) && port_of(i) > 4) m_err = 1;
    end
  endtask

  // Called with inputs driven just after a rising edge; compares then advances one cycle
  task automatic step();
    #2;
    model_eval();
    check("grant",     grant,  e_grant);
    check("out_valid", ovalid, e_valid);
    check("out_flit",  oflit,  e_flit);
    check("out_src",   osrc,   e_src);
    check("busy",      busy,   e_busy);
    check("err",       err,    m_err);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_all();
    rv = '0; rp = '0; tl = '0; rdy = '1;
    fl = {$urandom, $urandom, 16'($urandom)};
  endtask

  task automatic req(input int i, input int port, input bit tail);
    rv |= 5'(1) << i;
    rp[i*3 +: 3] = 3'(port);
    if (tail) tl |= 5'(1) << i;
    else      tl &= ~(5'(1) << i);
  endtask

  int rr_exp [6] = '{0, 1, 3, 0, 1, 3};
  int bp_rdy [6] = '{1, 0, 0, 1, 1, 1};

  initial begin
    int f;
    // Reset with every input requesting
    #1 rst = 1'b1;
    rv = '1; rp = 15'b100_011_010_001_000; tl = '1; rdy = '1;
    fl = {$urandom, $urandom, 16'($urandom)};
    #11;
    check("rst_grant", grant, 5'h0);
    check("rst_valid", ovalid, 5'h0);
    check("rst_flit",  oflit, 80'h0);
    check("rst_src",   osrc, 15'h0);
    check("rst_busy",  busy, 5'h0);
    check("rst_err",   err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Inputs 0 and 2 both request East with single-flit packets
    clear_all();
    req(0, 2, 1); req(2, 2, 1);
    #1 check("e_first", osrc[6 +: 3], 3'd0);
    step();
    #1 check("e_second", osrc[6 +: 3], 3'd2);
    step();

    // Round-robin on Local among inputs 0, 1, 3
    clear_all();
    req(0, 4, 1); req(1, 4, 1); req(3, 4, 1);
    for (int n = 0; n < 6; n++) begin
      fl = {$urandom, $urandom, 16'($urandom)};
      #1 check("rr_order", osrc[12 +: 3], 3'(rr_exp[n]));
      step();
    end

    // Wormhole lock on North: input 1 three flits, input 4 waiting
    clear_all();
    for (int c = 0; c < 4; c++) begin
      req(4, 0, 1);
      if (c < 3) req(1, 0, c == 2);
      else       rv[1] = 1'b0;
      #1 check("worm_src", osrc[0 +: 3], (c < 3) ? 3'd1 : 3'd4);
      if (c == 1 || c == 2) check("worm_busy", busy[0], 1'b1);
      step();
    end

    // Backpressure on West mid-packet; flit order preserved
    clear_all();
    f = 0;
    for (int c = 0; c < 6; c++) begin
      req(0, 3, f == 3);
      fl[0 +: 16] = 16'hA000 + 16'(f);
      rdy[3] = bp_rdy[c][0];
      #1;
      if (bp_rdy[c] == 0) begin
        check("bp_busy",  busy[3], 1'b1);
        check("bp_valid", ovalid[3], 1'b0);
      end else begin
        check("bp_flit", oflit[48 +: 16], 16'hA000 + 16'(f));
      end
      step();
      if (bp_rdy[c] != 0) f++;
    end

    // All five outputs in parallel
    clear_all();
    req(0, 1, 1); req(1, 0, 1); req(2, 3, 1); req(3, 2, 1); req(4, 4, 1);
    #1;
    check("par_grant", grant, 5'h1f);
    check("par_flit_s", oflit[16 +: 16], fl[0 +: 16]);
    check("par_flit_n", oflit[0 +: 16], fl[16 +: 16]);
    step();

    // Invalid port code on input 3
    clear_all();
    req(3, 6, 1); req(0, 1, 1);
    #1;
    check("inv_nogrant", grant[3], 1'b0);
    check("inv_err_pre", err, 1'b0);
    step();
    clear_all();
    #1 check("inv_err_set", err, 1'b1);
    step();

    // Asynchronous reset while East is locked
    clear_all();
    req(2, 2, 0);
    step();
    #1 check("ar_busy_pre", busy[2], 1'b1);
    rst = 1'b1;
    #1;
    check("ar_busy", busy, 5'h0);
    check("ar_grant", grant, 5'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_all();
    req(0, 2, 1); req(3, 2, 1);
    #1 check("ar_restart", osrc[6 +: 3], 3'd0);
    step();

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      clear_all();
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          req(i, ($urandom_range(0, 31) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4)),
              $urandom_range(0, 2) == 0);
        end
      end
      rdy = 5'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
